// File: rtl/tx_access_scheduler.sv
// Transmit-side medium access: carrier sense, DIFS/SIFS, backoff,
// ACK priority and ACK-timeout retransmission for the shared link.
module tx_access_scheduler #(
   parameter int CLK_FREQ         = 100_000_000,
   parameter int BIT_RATE         = 50000,
   parameter int SLOT_BITS        = 8,
   parameter int DIFS_SLOTS       = 2,
   parameter int SIFS_BITS        = 8,
   parameter int ACK_TIMEOUT_BITS = 256,
   parameter int MAX_RETRY        = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cardet,
   input  logic       ack_needed,
   input  logic [7:0] ack_dest,
   input  logic       ack_received,
   input  logic       data_req,
   input  logic [7:0] data_dest,
   input  logic       tx_done,
   output logic       tx_start,
   output logic       tx_kind,
   output logic [7:0] tx_dest,
   output logic       data_done,
   output logic       data_fail,
   output logic [3:0] retry_cnt
);

   localparam int CPB  = CLK_FREQ / BIT_RATE;
   localparam int DW   = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int DIFS = DIFS_SLOTS * SLOT_BITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIFS,
      S_BACKOFF,
      S_SEND,
      S_SIFS,
      S_WAIT_TX,
      S_WAIT_ACK
   } state_t;

   state_t      state_q;
   logic [DW-1:0] div_q;
   logic [7:0]  lfsr_q;
   logic        ack_pend_q;
   logic [7:0]  ack_dest_q;
   logic        armed_q;
   logic [7:0]  dest_q;
   logic        bcast_q;
   logic        data_act_q;
   logic [3:0]  retry_q;
   logic [7:0]  bo_q;
   logic        bo_ld_q;
   logic [15:0] tmr_q;
   logic [7:0]  slot_q;
   logic        tx_start_q;
   logic        tx_kind_q;
   logic [7:0]  tx_dest_q;
   logic        done_q;
   logic        fail_q;
   logic        tick;
   logic        ack_sent;

   // Contention window grows 3,7,15,... with retries, capped at 255
   function automatic logic [7:0] cw_of(input logic [3:0] r);
      if (r >= 4'd6) cw_of = 8'hFF;
      else           cw_of = 8'((9'd4 << r) - 9'd1);
   endfunction

   assign tick = (div_q == DW'(CPB - 1));

   assign ack_sent = (state_q == S_SIFS) && !cardet && tick &&
                     (tmr_q == 16'(SIFS_BITS - 1));

   assign tx_start  = tx_start_q;
   assign tx_kind   = tx_kind_q;
   assign tx_dest   = tx_dest_q;
   assign data_done = done_q;
   assign data_fail = fail_q;
   assign retry_cnt = retry_q;

   // Free-running bit-period divider
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      div_q <= '0;
      else if (tick) div_q <= '0;
      else           div_q <= div_q + 1'b1;
   end

   // Backoff random source, advances every clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr_q <= 8'hA5;
      else      lfsr_q <= {lfsr_q[6:0],
                           lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Pending-ACK latch; a newer request overwrites the destination
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_pend_q <= 1'b0;
         ack_dest_q <= 8'h00;
      end else if (ack_needed) begin
         ack_pend_q <= 1'b1;
         ack_dest_q <= ack_dest;
      end else if (ack_sent) begin
         ack_pend_q <= 1'b0;
      end
   end

   // Access FSM with registered transmitter and status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         armed_q    <= 1'b1;
         dest_q     <= 8'h00;
         bcast_q    <= 1'b0;
         data_act_q <= 1'b0;
         retry_q    <= 4'd0;
         bo_q       <= 8'h00;
         bo_ld_q    <= 1'b0;
         tmr_q      <= 16'd0;
         slot_q     <= 8'd0;
         tx_start_q <= 1'b0;
         tx_kind_q  <= 1'b0;
         tx_dest_q  <= 8'h00;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
         if (!data_req) armed_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (ack_pend_q) begin
                  tmr_q   <= 16'd0;
                  state_q <= S_SIFS;
               end else if (data_req && armed_q) begin
                  dest_q     <= data_dest;
                  bcast_q    <= (data_dest == 8'h2A);
                  retry_q    <= 4'd0;
                  armed_q    <= 1'b0;
                  data_act_q <= 1'b1;
                  bo_ld_q    <= 1'b0;
                  tmr_q      <= 16'd0;
                  state_q    <= S_DIFS;
               end
            end
            S_DIFS: begin
               if (ack_pend_q) begin
                  tmr_q   <= 16'd0;
                  state_q <= S_SIFS;
               end else if (cardet) begin
                  tmr_q <= 16'd0;
               end else if (tick) begin
                  if (tmr_q == 16'(DIFS - 1)) begin
                     if (!bo_ld_q) begin
                        bo_q    <= lfsr_q & cw_of(retry_q);
                        bo_ld_q <= 1'b1;
                     end
                     slot_q  <= 8'd0;
                     state_q <= S_BACKOFF;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
            end
            S_BACKOFF: begin
               if (ack_pend_q) begin
                  tmr_q   <= 16'd0;
                  state_q <= S_SIFS;
               end else if (cardet) begin
                  tmr_q   <= 16'd0;
                  state_q <= S_DIFS;
               end else if (bo_q == 8'h00) begin
                  state_q <= S_SEND;
               end else if (tick) begin
                  if (slot_q == 8'(SLOT_BITS - 1)) begin
                     slot_q <= 8'd0;
                     bo_q   <= bo_q - 8'd1;
                  end else begin
                     slot_q <= slot_q + 8'd1;
                  end
               end
            end
            S_SEND: begin
               tx_start_q <= 1'b1;
               tx_kind_q  <= 1'b0;
               tx_dest_q  <= dest_q;
               state_q    <= S_WAIT_TX;
            end
            S_SIFS: begin
               if (cardet) begin
                  tmr_q <= 16'd0;
               end else if (tick) begin
                  if (tmr_q == 16'(SIFS_BITS - 1)) begin
                     tx_start_q <= 1'b1;
                     tx_kind_q  <= 1'b1;
                     tx_dest_q  <= ack_dest_q;
                     state_q    <= S_WAIT_TX;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
            end
            S_WAIT_TX: begin
               if (tx_done) begin
                  tmr_q <= 16'd0;
                  if (tx_kind_q) begin
                     state_q <= data_act_q ? S_DIFS : S_IDLE;
                  end else if (bcast_q) begin
                     done_q     <= 1'b1;
                     data_act_q <= 1'b0;
                     state_q    <= S_IDLE;
                  end else begin
                     state_q <= S_WAIT_ACK;
                  end
               end
            end
            S_WAIT_ACK: begin
               if (ack_received) begin
                  done_q     <= 1'b1;
                  data_act_q <= 1'b0;
                  state_q    <= S_IDLE;
               end else if (tick) begin
                  if (tmr_q == 16'(ACK_TIMEOUT_BITS - 1)) begin
                     retry_q <= retry_q + 4'd1;
                     tmr_q   <= 16'd0;
                     if (retry_q >= 4'(MAX_RETRY)) begin
                        fail_q     <= 1'b1;
                        data_act_q <= 1'b0;
                        state_q    <= S_IDLE;
                     end else begin
                        bo_ld_q <= 1'b0;
                        state_q <= S_DIFS;
                     end
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_access_scheduler.sv
// Directed bench for tx_access_scheduler: 4 clk/bit, 32 clk/slot,
// DIFS 64 clk, SIFS 32 clk, ACK timeout 1024 clk.
module tb_tx_access_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cardet = 1'b0;
   logic       ack_needed = 1'b0;
   logic [7:0] ack_dest = 8'h00;
   logic       ack_received = 1'b0;
   logic       data_req = 1'b0;
   logic [7:0] data_dest = 8'h00;
   logic       tx_done = 1'b0;
   logic       tx_start;
   logic       tx_kind;
   logic [7:0] tx_dest;
   logic       data_done;
   logic       data_fail;
   logic [3:0] retry_cnt;

   int checks = 0;
   int failures = 0;
   int ns = 0;
   int nd = 0;
   int nf = 0;

   tx_access_scheduler #(
      .CLK_FREQ(400),
      .BIT_RATE(100),
      .SLOT_BITS(8),
      .DIFS_SLOTS(2),
      .SIFS_BITS(8),
      .ACK_TIMEOUT_BITS(256),
      .MAX_RETRY(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cardet(cardet),
      .ack_needed(ack_needed),
      .ack_dest(ack_dest),
      .ack_received(ack_received),
      .data_req(data_req),
      .data_dest(data_dest),
      .tx_done(tx_done),
      .tx_start(tx_start),
      .tx_kind(tx_kind),
      .tx_dest(tx_dest),
      .data_done(data_done),
      .data_fail(data_fail),
      .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
      if (tx_start)  ns++;
      if (data_done) nd++;
      if (data_fail) nf++;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int v,
                          input int lo, input int hi);
      checks++;
      assert (v >= lo && v <= hi) else begin
         failures++;
         $error("FAIL %s obs=%0d exp=%0d..%0d", tag, v, lo, hi);
      end
   endtask

   task automatic wait_start(input int maxc, output int c);
      c = 0;
      do begin
         step();
         c++;
      end while (!tx_start && c < maxc);
   endtask

   task automatic wait_fail(input int maxc, output int c);
      c = 0;
      do begin
         step();
         c++;
      end while (!data_fail && c < maxc);
   endtask

   task automatic pulse_done();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   task automatic pulse_ack_rx();
      ack_received = 1'b1;
      step();
      ack_received = 1'b0;
   endtask

   task automatic pulse_ack_need(input logic [7:0] d);
      ack_needed = 1'b1;
      ack_dest   = d;
      step();
      ack_needed = 1'b0;
   endtask

   initial begin
      int c;
      int pre;
      int cw;

      // reset values
      steps(3);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_kind", tx_kind, 0);
      chk("rst_tx_dest", tx_dest, 0);
      chk("rst_done", data_done, 0);
      chk("rst_fail", data_fail, 0);
      chk("rst_retry", retry_cnt, 0);
      rst = 1'b1;
      steps(2);

      // unicast, ACKed after 100 clk
      data_dest = 8'h11;
      data_req  = 1'b1;
      wait_start(400, c);
      chk_rng("t1_lat", c, 56, 176);
      chk("t1_kind", tx_kind, 0);
      chk("t1_dest", tx_dest, 8'h11);
      data_req = 1'b0;
      steps(20);
      chk("t1_dest_hold", tx_dest, 8'h11);
      pulse_done();
      nd = 0;
      steps(99);
      chk("t1_no_early_done", nd, 0);
      pulse_ack_rx();
      chk("t1_done", data_done, 1);
      chk("t1_retry", retry_cnt, 0);
      step();
      chk("t1_done_pulse", data_done, 0);

      // broadcast: done the cycle after tx_done, no ACK wait
      data_dest = 8'h2A;
      data_req  = 1'b1;
      wait_start(400, c);
      chk_rng("t2_lat", c, 56, 176);
      chk("t2_dest", tx_dest, 8'h2A);
      data_req = 1'b0;
      steps(10);
      nd = 0;
      pulse_done();
      chk("t2_done_next", data_done, 1);
      steps(300);
      chk("t2_single_done", nd, 1);

      // ACK from IDLE, sent once only
      pulse_ack_need(8'h9C);
      wait_start(100, c);
      chk_rng("t3_sifs", c, 26, 40);
      chk("t3_kind", tx_kind, 1);
      chk("t3_dest", tx_dest, 8'h9C);
      steps(5);
      pulse_done();
      ns = 0;
      steps(200);
      chk("t3_no_repeat", ns, 0);

      // ACK preempts data contention, data resumes from DIFS
      data_dest = 8'h44;
      data_req  = 1'b1;
      steps(20);
      pulse_ack_need(8'h33);
      wait_start(100, c);
      chk_rng("t4_ack_lat", c, 26, 40);
      chk("t4_ack_kind", tx_kind, 1);
      chk("t4_ack_dest", tx_dest, 8'h33);
      steps(5);
      pulse_done();
      wait_start(400, c);
      chk_rng("t4_data_lat", c, 56, 176);
      chk("t4_data_kind", tx_kind, 0);
      chk("t4_data_dest", tx_dest, 8'h44);
      data_req = 1'b0;
      pulse_done();
      steps(10);
      pulse_ack_rx();
      chk("t4_done", data_done, 1);

      // carrier during backoff freezes it; full DIFS after release
      data_dest = 8'h5C;
      data_req  = 1'b1;
      ns = 0;
      steps(80);
      pre = ns;
      cardet = 1'b1;
      ns = 0;
      steps(500);
      chk("t5_hold_no_start", ns, 0);
      cardet = 1'b0;
      if (pre == 0) begin
         wait_start(400, c);
         chk_rng("t5_resume_lat", c, 60, 176);
      end
      chk("t5_kind", tx_kind, 0);
      chk("t5_dest", tx_dest, 8'h5C);
      data_req = 1'b0;
      pulse_done();
      steps(5);
      pulse_ack_rx();
      chk("t5_done", data_done, 1);

      // no ACK: six attempts then failure
      data_dest = 8'hB7;
      data_req  = 1'b1;
      ns = 0;
      nd = 0;
      for (int k = 0; k < 6; k++) begin
         cw = (4 << k) - 1;
         wait_start(6000, c);
         if (k == 0) chk_rng("t6_lat0", c, 56, 176);
         else        chk_rng("t6_retry_lat", c, 1075, 1104 + cw * 32);
         chk("t6_retry_cnt", retry_cnt, k);
         chk("t6_dest", tx_dest, 8'hB7);
         steps(5);
         pulse_done();
      end
      wait_fail(1200, c);
      chk_rng("t6_fail_lat", c, 1015, 1030);
      chk("t6_fail", data_fail, 1);
      chk("t6_retry_final", retry_cnt, 6);
      chk("t6_starts", ns, 6);
      chk("t6_no_done", nd, 0);
      ns = 0;
      steps(200);
      chk("t6_not_rearmed", ns, 0);
      data_req = 1'b0;
      step();

      // reset while waiting for an ACK
      data_dest = 8'h66;
      data_req  = 1'b1;
      wait_start(400, c);
      chk_rng("t7_lat", c, 56, 176);
      steps(3);
      pulse_done();
      steps(50);
      rst = 1'b0;
      data_req = 1'b0;
      #1;
      chk("t7_rst_dest", tx_dest, 0);
      chk("t7_rst_start", tx_start, 0);
      chk("t7_rst_kind", tx_kind, 0);
      chk("t7_rst_done", data_done, 0);
      chk("t7_rst_fail", data_fail, 0);
      steps(5);
      rst = 1'b1;
      ns = 0;
      nd = 0;
      nf = 0;
      steps(1300);
      chk("t7_quiet_start", ns, 0);
      chk("t7_quiet_done", nd, 0);
      chk("t7_quiet_fail", nf, 0);
      data_dest = 8'h77;
      data_req  = 1'b1;
      wait_start(400, c);
      chk_rng("t7_new_lat", c, 56, 176);
      chk("t7_new_dest", tx_dest, 8'h77);
      data_req = 1'b0;
      pulse_done();
      steps(10);
      pulse_ack_rx();
      chk("t7_new_done", data_done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tx_access_scheduler.md
Name: tx_access_scheduler

Overview:
- Transmit-side medium-access controller. Decides when the shared link may be driven and which frame kind goes out.
- Arbitrates between pending ACK responses (from the receive path's ACK_needed) and user data frames.
- Enforces carrier sense, DIFS/SIFS spacing and binary-exponential random backoff.
- Handles ACK timeout with retransmission. Sits between the receiver/user logic and the transmitter datapath.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- BIT_RATE, 50000, link bit rate in bits/s; CLKS_PER_BIT = CLK_FREQ/BIT_RATE (integer).
- SLOT_BITS, 8, bit periods per backoff slot.
- DIFS_SLOTS, 2, idle slots required before data contention.
- SIFS_BITS, 8, bit periods between idle channel and ACK transmission.
- ACK_TIMEOUT_BITS, 256, bit periods to wait for an ACK after a unicast data frame.
- MAX_RETRY, 5, retransmissions allowed before failure.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cardet  in  1  carrier detected (channel busy).
- ack_needed  in  1  one-cycle pulse: a received frame requires an ACK.
- ack_dest  in  8  MAC to ACK; valid with ack_needed.
- ack_received  in  1  one-cycle pulse: ACK addressed to us received.
- data_req  in  1  level: a data frame is ready in the transmit buffer.
- data_dest  in  8  destination MAC of the data frame; valid while data_req is high.
- tx_done  in  1  one-cycle pulse from the transmitter: frame fully sent.
- tx_start  out  1  one-cycle pulse: transmitter begins a frame.
- tx_kind  out  1  0 = data frame, 1 = ACK frame; stable from tx_start to tx_done.
- tx_dest  out  8  destination MAC; stable from tx_start to tx_done.
- data_done  out  1  one-cycle pulse: data frame delivered (ACKed, or broadcast sent).
- data_fail  out  1  one-cycle pulse: retries exhausted.
- retry_cnt  out  4  retransmissions of the current data frame.

Behaviour:
- Reset: all outputs 0; state IDLE; ack_pend 0; armed 1; LFSR = 8'hA5.
- Bit tick: a one-cycle pulse every CLKS_PER_BIT clocks from a free-running counter. Slot = SLOT_BITS ticks. All timers count ticks.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clock, never zero.
- ACK latch: ack_needed sets ack_pend and captures ack_dest in any state. A second ack_needed while ack_pend is set overwrites the captured dest. ack_pend clears on tx_start with tx_kind=1.
- Data acceptance: only in IDLE, and only when data_req=1 and armed=1. On acceptance:
  - capture data_dest;
  - retry_cnt=0;
  - bcast = (data_dest==8'h2A);
  - armed=0.
- armed is set again when data_req is sampled 0.
- States:
  - IDLE: if ack_pend -> SIFS. Else if a data frame is accepted -> DIFS.
  - DIFS: counts DIFS_SLOTS*SLOT_BITS consecutive ticks with cardet=0. cardet=1 restarts the count. If ack_pend -> SIFS (data context retained). On completion, if the backoff count is not loaded, load bo = LFSR & CW, then -> BACKOFF.
    - CW = (2^(retry_cnt+2))-1, capped at 255.
  - BACKOFF: decrement bo at each slot boundary while cardet=0.
    - cardet=1 freezes bo and returns to DIFS; bo is preserved, not reloaded.
    - ack_pend -> SIFS; bo is preserved.
    - bo==0 -> SEND_DATA.
  - SEND_DATA: tx_start=1, tx_kind=0, tx_dest=captured dest for one cycle -> WAIT_TX.
  - SIFS: waits until cardet=0, then SIFS_BITS ticks with cardet=0, then issues tx_start with tx_kind=1 and tx_dest=ack dest -> WAIT_TX.
  - WAIT_TX: holds tx_kind and tx_dest until tx_done.
    - After an ACK frame: -> DIFS if a data frame is in progress, else IDLE.
    - After a broadcast data frame: data_done pulse -> IDLE.
    - After a unicast data frame: -> WAIT_ACK with the timer cleared.
  - WAIT_ACK:
    - ack_received -> data_done pulse, IDLE.
    - Timer reaching ACK_TIMEOUT_BITS ticks -> retry_cnt+1. If the new value is greater than MAX_RETRY: data_fail pulse, retry_cnt holds its value, -> IDLE. Otherwise the backoff is marked unloaded -> DIFS.
    - ack_needed here stays pending and is served from the next DIFS/IDLE.
  - ack_received outside WAIT_ACK is ignored.
- Simultaneous events: ack_received and timeout in the same cycle counts as success.
- tx_start never asserts while in WAIT_TX or WAIT_ACK.
- An ACK always preempts data contention but never a frame in flight.
- Reset mid-operation: immediate return to reset values. The data frame is dropped and no done/fail pulse is issued.

Test Plan:
- Bench parameters: CLK_FREQ=400, BIT_RATE=100 (4 clk/bit, 32 clk/slot, DIFS=64 clk).
- Idle channel, data_req with dest 8'h11 -> tx_start with tx_kind=0, tx_dest=8'h11 after 64 + (0..3)*32 clk. tx_done, then ack_received 100 clk later -> data_done pulse, retry_cnt=0.
- Broadcast dest 8'h2A -> tx_done is followed by data_done the next cycle, with no ACK wait.
- Unicast with no ACK, MAX_RETRY=5 -> six tx_start pulses, with timeouts at 1024 clk after each tx_done. retry_cnt reaches 6, then data_fail pulse, then IDLE. Backoff draws stay within the CW of 3, 7, 15, 31, 63, 127 respectively.
- cardet held high for 500 clk during BACKOFF with bo=2 -> no tx_start. After release: full DIFS, then the remaining slots only.
- ack_needed with ack_dest 8'h33 during DIFS of a data frame -> ACK sent first (tx_kind=1, dest 8'h33, 32 clk after channel idle). Then the data frame resumes from DIFS.
- rst low during WAIT_ACK -> outputs 0 immediately. No data_done/data_fail. No tx_start until data_req is seen low, then high again.
